// File: rtl/lifo_drain.sv
// -----------------------------------------------------------------------------
// lifo_drain
//   Downstream stage of the 16x8 LIFO. When a start pulse arrives in IDLE, the
//   block pops the LIFO until it is empty and streams the bytes out in LIFO order
//   on a valid/ready interface. The final byte is marked with m_last.
//   The LIFO returns data one cycle after each pop. A 2-entry output buffer
//   absorbs that latency, so the stream runs at one byte per cycle while m_ready
//   stays high.
//
// Ports
//   clock       in   rising-edge clock
//   resetn      in   synchronous, active-low reset
//   start       in   1-cycle drain request (honoured only in IDLE)
//   lifo_empty  in   LIFO empty flag
//   lifo_rd_en  out  LIFO pop strobe (combinational)
//   lifo_data   in   LIFO read data, valid the cycle after a pop
//   m_valid     out  output byte valid
//   m_ready     in   consumer ready
//   m_data      out  output byte
//   m_last      out  final byte of the drain (qualified by m_valid)
//   busy        out  drain in progress (DRAIN or FLUSH)
//   done        out  1-cycle pulse at the end of a drain
//   byte_count  out  bytes accepted since the last honoured start
// -----------------------------------------------------------------------------
module lifo_drain #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              lifo_empty,
    output logic              lifo_rd_en,
    input  logic [DATA_W-1:0] lifo_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  byte_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          occ_q, occ_d;
    logic [DATA_W-1:0]   buf0_q, buf0_d;
    logic [DATA_W-1:0]   buf1_q, buf1_d;
    logic                last0_q, last0_d;
    logic                last1_q, last1_d;
    logic                inflight_q;
    logic                last_seen_q, last_seen_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    byte_count_q, byte_count_d;

    logic                accept_s;
    logic                capture_s;
    logic [2:0]          pending_s;
    logic [1:0]          occ_after_acc_s;
    logic                rd_en_s;

    // Outputs come straight from registered state.
    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = buf0_q;
    assign m_last     = last0_q & m_valid;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign byte_count = byte_count_q;
    assign lifo_rd_en = rd_en_s;

    assign accept_s  = m_valid & m_ready;
    assign capture_s = inflight_q;

    // Pop gating. Count buffered plus in-flight bytes, minus the byte leaving
    // this cycle, so that a pop never lands on a full buffer. accept_s implies
    // occ_q >= 1, so the subtraction cannot underflow.
    always_comb begin
        pending_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, accept_s};
        if ((state_q == ST_DRAIN) && !lifo_empty && !last_seen_q && (pending_s < 3'd2)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Output buffer update. Shift the head out on accept, then append any
    // captured byte at the new tail. Both may happen in the same cycle.
    always_comb begin
        occ_after_acc_s = occ_q - {1'b0, accept_s};
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        if (accept_s) begin
            buf0_d  = buf1_q;
            last0_d = last1_q;
        end else begin
            buf0_d  = buf0_q;
            last0_d = last0_q;
        end
        if (capture_s) begin
            if (occ_after_acc_s == 2'd0) begin
                buf0_d  = lifo_data;
                last0_d = lifo_empty;
            end else begin
                buf1_d  = lifo_data;
                last1_d = lifo_empty;
            end
        end else begin
            buf1_d = buf1_q;
        end
        occ_d = occ_after_acc_s + {1'b0, capture_s};
    end

    // Control FSM next state, the done pulse, and the accepted-byte counter.
    always_comb begin
        state_d      = state_q;
        last_seen_d  = last_seen_q;
        done_d       = 1'b0;
        byte_count_d = byte_count_q;
        if (accept_s && (byte_count_q < CNT_W'(DEPTH))) begin
            byte_count_d = byte_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            byte_count_d = byte_count_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    byte_count_d = {CNT_W{1'b0}};
                    last_seen_d  = 1'b0;
                    if (lifo_empty) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // lifo_empty seen alongside a capture marks the byte as the last one.
                if (capture_s && lifo_empty) begin
                    last_seen_d = 1'b1;
                    state_d     = ST_FLUSH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                if (accept_s && (occ_q == 2'd1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. A reset discards buffered and in-flight bytes.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            occ_q        <= 2'd0;
            buf0_q       <= {DATA_W{1'b0}};
            buf1_q       <= {DATA_W{1'b0}};
            last0_q      <= 1'b0;
            last1_q      <= 1'b0;
            inflight_q   <= 1'b0;
            last_seen_q  <= 1'b0;
            done_q       <= 1'b0;
            byte_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            last0_q      <= last0_d;
            last1_q      <= last1_d;
            inflight_q   <= rd_en_s;
            last_seen_q  <= last_seen_d;
            done_q       <= done_d;
            byte_count_q <= byte_count_d;
        end
    end

endmodule

// File: tb/tb_lifo_drain.sv
// Testbench for lifo_drain: a behavioural 16x8 LIFO drives the DUT, and a
// queue-based scoreboard checks the output stream.
module tb_lifo_drain;

    logic       clock;
    logic       resetn;
    logic       start;
    logic       lifo_empty;
    logic       lifo_rd_en;
    logic [7:0] lifo_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
    logic       done;
    logic [4:0] byte_count;

    lifo_drain #(.DATA_W(8), .DEPTH(16)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .lifo_empty (lifo_empty),
        .lifo_rd_en (lifo_rd_en),
        .lifo_data  (lifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done),
        .byte_count (byte_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural LIFO with a registered read port.
    logic [7:0] mem [16];
    int         sp;
    logic       push_en;
    logic [7:0] push_data;
    assign lifo_empty = (sp == 0);

    always @(posedge clock) begin
        if (!resetn) begin
            sp        <= 0;
            lifo_data <= 8'h00;
        end else begin
            if (push_en && sp < 16) begin
                mem[sp] <= push_data;
                sp      <= sp + 1;
            end
            if (lifo_rd_en && sp > 0) begin
                lifo_data <= mem[sp-1];
                sp        <= sp - 1;
            end
        end
    end

    int cyc;
    always @(posedge clock) cyc <= cyc + 1;

    int errors;
    int checks;
    logic [8:0] sb [$];
    logic [7:0] pushed [$];
    int acc_cycles [$];
    int done_cnt;
    int done_cyc;
    int rd_cnt;
    int valid_cnt;
    logic       stall_prev;
    logic [7:0] stall_data;
    logic       stall_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares accepted bytes against the scoreboard, checks that a
    // stalled head stays stable, and counts events.
    always @(negedge clock) begin
        if (resetn) begin
            if (lifo_rd_en) begin
                rd_cnt++;
                chk("rd_en_while_empty", {31'd0, lifo_empty}, 32'd0);
            end
            if (m_valid) valid_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (stall_prev) begin
                chk("stall_valid_held", {31'd0, m_valid}, 32'd1);
                chk("stall_data_stable", {24'd0, m_data}, {24'd0, stall_data});
                chk("stall_last_stable", {31'd0, m_last}, {31'd0, stall_last});
            end
            if (m_valid && m_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", m_data, cyc);
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    if (m_data !== e[7:0] || m_last !== e[8]) begin
                        errors++;
                        $display("FAIL stream_byte: got data %0h last %0b expected data %0h last %0b",
                                 m_data, m_last, e[7:0], e[8]);
                    end
                    acc_cycles.push_back(cyc);
                end
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            stall_last = m_last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        push_en   = 1'b1;
        push_data = v;
        pushed.push_back(v);
        tick();
        push_en = 1'b0;
    endtask

    // mode 0: ready always high; 1: random ready; 2: 10-cycle stall;
    // 3: ready low every third cycle, plus start re-pulsed while busy.
    task automatic run_drain(input int n, input int mode);
        int d0, r0, v0, start_cyc, t;
        bit timed_out;
        d0 = done_cnt; r0 = rd_cnt; v0 = valid_cnt;
        acc_cycles.delete();
        for (int i = n - 1; i >= 0; i--) sb.push_back({(i == 0), pushed[i]});
        start     = 1'b1;
        m_ready   = (mode == 2) ? 1'b1 : 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        timed_out = 1'b1;
        for (t = 1; t < 400; t++) begin
            if (done_cnt != d0) begin
                timed_out = 1'b0;
                break;
            end
            case (mode)
                1:       m_ready = 1'($urandom_range(0, 1));
                2:       m_ready = !(t >= 4 && t < 14);
                3:       m_ready = (t % 3 != 0);
                default: m_ready = 1'b1;
            endcase
            start = (mode == 3) ? busy : 1'b0;
            tick();
        end
        start   = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        if (timed_out) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: got no done expected done within 400 cycles");
        end
        chk("done_pulses", done_cnt - d0, 32'd1);
        chk("byte_count", {27'd0, byte_count}, n);
        chk("sb_drained", sb.size(), 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
        if (n == 0) begin
            chk("empty_done_latency", done_cyc - start_cyc, 32'd1);
            chk("empty_no_rd", rd_cnt - r0, 32'd0);
            chk("empty_no_valid", valid_cnt - v0, 32'd0);
        end else if (mode == 0) begin
            chk("first_byte_latency", acc_cycles[0] - start_cyc, 32'd3);
            chk("throughput", acc_cycles[n-1] - acc_cycles[0], n - 1);
            chk("done_after_last", done_cyc - acc_cycles[n-1], 32'd1);
        end
        pushed.delete();
        sb.delete();
    endtask

    initial begin
        int d0;
        errors = 0; checks = 0; done_cnt = 0; rd_cnt = 0; valid_cnt = 0; done_cyc = 0;
        stall_prev = 1'b0; cyc = 0;
        resetn = 1'b0; start = 1'b0; m_ready = 1'b0; push_en = 1'b0; push_data = 8'h00;
        tick(); tick(); tick();
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_rd_en", {31'd0, lifo_rd_en}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_byte_count", {27'd0, byte_count}, 32'd0);
        resetn = 1'b1;
        tick();

        // 1: three bytes, ready high -> A3, A2, A1 back to back
        push(8'hA1); push(8'hA2); push(8'hA3);
        run_drain(3, 0);

        // 2: start with the LIFO empty
        run_drain(0, 0);

        // 3: full LIFO, random ready
        for (int i = 0; i < 16; i++) push(8'(i));
        run_drain(16, 1);

        // 4: 10-cycle stall mid-drain
        for (int i = 0; i < 6; i++) push(8'h40 + 8'(i));
        run_drain(6, 2);

        // 6: start re-pulsed during DRAIN and FLUSH
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        run_drain(5, 3);

        // 5: reset mid-drain with the buffer full
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        pushed.delete();
        m_ready = 1'b0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("pre_reset_buffered", {31'd0, m_valid}, 32'd1);
        d0 = done_cnt;
        resetn = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("mid_rst_valid_rd", {30'd0, m_valid, lifo_rd_en}, 32'd0);
        chk("mid_rst_data_last", {23'd0, m_data, m_last}, 32'd0);
        chk("mid_rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("mid_rst_byte_count", {27'd0, byte_count}, 32'd0);
        #1;
        resetn  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("no_done_after_rst", done_cnt - d0, 32'd0);
        chk("idle_after_rst", {30'd0, busy, m_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
